// File: rtl/hcube_path_seq.sv
// hcube_path_seq: greedy power-of-two split of a node count into up to 3 hypercube groups, emitted hop by hop
//   clk, rst_n       : clock, synchronous active-low reset
//   start_i, num_i   : request strobe (taken only in IDLE) and node count 0..31
//   busy_o           : high outside IDLE
//   hop_*            : registered hop record (group, dimension, group base, last) with valid/ready handshake
//   grp_cnt_o, err_o : groups used and truncation flag, held from CALC exit until the next accepted start
//   done_o           : one-cycle completion pulse
module hcube_path_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [4:0] num_i,
  output logic       busy_o,
  output logic       hop_valid_o,
  input  logic       hop_ready_i,
  output logic [1:0] hop_grp_o,
  output logic [2:0] hop_dim_o,
  output logic [4:0] hop_base_o,
  output logic       hop_last_o,
  output logic [1:0] grp_cnt_o,
  output logic       err_o,
  output logic       done_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [4:0]      r_q, r_d;
  logic [2:0][2:0] len_q, len_d;
  logic [2:0][4:0] base_q, base_d;
  logic [1:0]      grp_cnt_q, grp_cnt_d;
  logic            err_q, err_d;
  logic [1:0]      hop_grp_q, hop_grp_d;
  logic [2:0]      hop_dim_q, hop_dim_d;
  logic [4:0]      hop_base_q, hop_base_d;
  logic            hop_last_q, hop_last_d;

  logic [2:0][2:0] c_len;
  logic [2:0][4:0] c_base;
  logic [1:0]      c_cnt;
  logic            c_err;
  logic [4:0]      rem, acc;
  logic [2:0]      k;

  logic [2:0][2:0] use_len;
  logic [5:0]      nx;
  logic            nx_last;

  function automatic logic [2:0] msb(input logic [4:0] v);
    msb = '0;
    for (int i = 0; i < 5; i++)
      if (v[i]) msb = i[2:0];
  endfunction

  // First hop at or after (g0, d0) in emit order: {found, grp, dim}
  function automatic logic [5:0] seek(input logic [1:0] g0, input logic [2:0] d0,
                                      input logic [2:0][2:0] l);
    logic       f;
    logic [1:0] gs;
    logic [2:0] ds;
    f  = 1'b0;
    gs = '0;
    ds = '0;
    for (int g = 0; g < 3; g++) begin
      if (!f && g >= int'(g0)) begin
        ds = (g == int'(g0)) ? d0 : 3'd0;
        if (ds < l[g]) begin
          f  = 1'b1;
          gs = g[1:0];
        end
      end
    end
    return {f, gs, ds};
  endfunction

  function automatic logic later(input logic [1:0] g0, input logic [2:0][2:0] l);
    later = 1'b0;
    for (int g = 0; g < 3; g++)
      if (g > int'(g0) && l[g] != 3'd0) later = 1'b1;
  endfunction

  // Greedy decomposition of the latched count; unused groups keep the running base
  always_comb begin
    rem    = r_q;
    acc    = '0;
    k      = '0;
    c_len  = '0;
    c_base = '0;
    c_cnt  = '0;
    for (int g = 0; g < 3; g++) begin
      k         = msb(rem);
      c_base[g] = acc;
      if (rem != 5'd0) begin
        c_len[g] = k;
        acc      = acc + (5'd1 << k);
        rem      = rem - (5'd1 << k);
        c_cnt    = c_cnt + 2'd1;
      end
    end
    c_err = rem != 5'd0;
  end

  // Next hop: in CALC the first one from fresh lengths, in EMIT the successor of the current hop
  always_comb begin
    use_len = (state_q == S_CALC) ? c_len : len_q;
    nx      = (state_q == S_CALC) ? seek(2'd0, 3'd0, use_len)
                                  : seek(hop_grp_q, hop_dim_q + 3'd1, use_len);
    nx_last = (nx[2:0] + 3'd1 == use_len[nx[4:3]]) && !later(nx[4:3], use_len);
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    len_d      = len_q;
    base_d     = base_q;
    grp_cnt_d  = grp_cnt_q;
    err_d      = err_q;
    hop_grp_d  = hop_grp_q;
    hop_dim_d  = hop_dim_q;
    hop_base_d = hop_base_q;
    hop_last_d = hop_last_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          r_d     = num_i;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        len_d      = c_len;
        base_d     = c_base;
        grp_cnt_d  = c_cnt;
        err_d      = c_err;
        state_d    = nx[5] ? S_EMIT : S_DONE;
        hop_grp_d  = nx[4:3];
        hop_dim_d  = nx[2:0];
        hop_base_d = c_base[nx[4:3]];
        hop_last_d = nx[5] && nx_last;
      end
      S_EMIT: begin
        if (hop_ready_i) begin
          if (hop_last_q) begin
            state_d    = S_DONE;
            hop_last_d = 1'b0;
          end else begin
            hop_grp_d  = nx[4:3];
            hop_dim_d  = nx[2:0];
            hop_base_d = base_q[nx[4:3]];
            hop_last_d = nx_last;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      grp_cnt_q  <= '0;
      err_q      <= 1'b0;
      hop_grp_q  <= '0;
      hop_dim_q  <= '0;
      hop_base_q <= '0;
      hop_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      len_q      <= len_d;
      base_q     <= base_d;
      grp_cnt_q  <= grp_cnt_d;
      err_q      <= err_d;
      hop_grp_q  <= hop_grp_d;
      hop_dim_q  <= hop_dim_d;
      hop_base_q <= hop_base_d;
      hop_last_q <= hop_last_d;
    end
  end

  assign busy_o      = state_q != S_IDLE;
  assign hop_valid_o = state_q == S_EMIT;
  assign done_o      = state_q == S_DONE;
  assign hop_grp_o   = hop_grp_q;
  assign hop_dim_o   = hop_dim_q;
  assign hop_base_o  = hop_base_q;
  assign hop_last_o  = hop_last_q;
  assign grp_cnt_o   = grp_cnt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_hcube_path_seq.sv
// tb_hcube_path_seq: scoreboard bench for hcube_path_seq against an arithmetic decomposition model
module tb_hcube_path_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] num_i = '0;
  logic       hop_ready_i = 1'b0;
  logic       busy_o, hop_valid_o, hop_last_o, err_o, done_o;
  logic [1:0] hop_grp_o, grp_cnt_o;
  logic [2:0] hop_dim_o;
  logic [4:0] hop_base_o;

  always #5 clk = ~clk;

  hcube_path_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_i(num_i), .busy_o(busy_o),
    .hop_valid_o(hop_valid_o), .hop_ready_i(hop_ready_i), .hop_grp_o(hop_grp_o),
    .hop_dim_o(hop_dim_o), .hop_base_o(hop_base_o), .hop_last_o(hop_last_o),
    .grp_cnt_o(grp_cnt_o), .err_o(err_o), .done_o(done_o)
  );

  typedef struct {int g; int d; int b; int l;} hop_t;
  hop_t hq[$];
  int   pat[$];
  int   exp_cnt, exp_err;
  bit   pending, done_seen, exp_done_next;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Largest power of two not above the remainder, three times; every group of size 2^k yields k hops
  task automatic model(input int n);
    int rem, acc, p, k;
    hop_t h;
    rem = n;
    acc = 0;
    exp_cnt = 0;
    hq.delete();
    for (int g = 0; g < 3; g++) begin
      if (rem > 0) begin
        p = 1;
        k = 0;
        while (p * 2 <= rem) begin
          p = p * 2;
          k++;
        end
        for (int d = 0; d < k; d++) begin
          h.g = g; h.d = d; h.b = acc; h.l = 0;
          hq.push_back(h);
        end
        acc += p;
        rem -= p;
        exp_cnt++;
      end
    end
    exp_err = (rem > 0) ? 1 : 0;
    if (hq.size() > 0) hq[hq.size()-1].l = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_done_next) begin
        chk("done_after_last", int'(done_o), 1);
        exp_done_next = 1'b0;
      end
      if (hop_valid_o) begin
        if (hq.size() == 0) chk("hop_unexpected", 1, 0);
        else begin
          chk("hop_grp", int'(hop_grp_o), hq[0].g);
          chk("hop_dim", int'(hop_dim_o), hq[0].d);
          chk("hop_base", int'(hop_base_o), hq[0].b);
          chk("hop_last", int'(hop_last_o), hq[0].l);
          if (hop_ready_i) begin
            if (hq[0].l != 0) exp_done_next = 1'b1;
            void'(hq.pop_front());
          end
        end
      end
      if (done_o) begin
        chk("done_expected", int'(pending), 1);
        chk("grp_cnt", int'(grp_cnt_o), exp_cnt);
        chk("err", int'(err_o), exp_err);
        chk("hops_left", hq.size(), 0);
        pending = 1'b0;
        done_seen = 1'b1;
      end
    end
  end

  task automatic run(input int n, input int pct, input bit poke);
    int nexp;
    @(negedge clk);
    model(n);
    nexp = hq.size();
    done_seen = 1'b0;
    exp_done_next = 1'b0;
    pending = 1'b1;
    start_i = 1'b1;
    num_i = n[4:0];
    hop_ready_i = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b0;
    num_i = 5'($urandom);
    chk("calc_busy", int'(busy_o), 1);
    chk("calc_no_valid", int'(hop_valid_o), 0);
    @(posedge clk);
    #1 chk("t2_valid", int'(hop_valid_o), (nexp > 0) ? 1 : 0);
    chk("t2_done", int'(done_o), (nexp == 0) ? 1 : 0);
    for (int c = 0; c < 400 && !done_seen; c++) begin
      hop_ready_i = (pat.size() > 0) ? pat.pop_front() != 0 : ($urandom_range(99) < pct);
      start_i = poke && c == 1;
      num_i = 5'($urandom);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    if (!done_seen) chk("timeout", 0, 1);
    chk("idle_busy", int'(busy_o), 0);
    chk("done_one_cycle", int'(done_o), 0);
  endtask

  initial begin
    pending = 1'b0;
    done_seen = 1'b0;
    exp_done_next = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", int'({busy_o, hop_valid_o, hop_last_o, done_o, err_o,
                                  grp_cnt_o, hop_grp_o, hop_dim_o, hop_base_o}), 0);
    rst_n = 1'b1;
    run(13, 100, 1'b0);
    run(15, 100, 1'b0);
    run(16, 100, 1'b0);
    run(1, 100, 1'b0);
    run(0, 100, 1'b0);
    pat = '{1, 0, 0, 0, 1, 1};
    run(7, 100, 1'b0);
    run(31, 60, 1'b1);
    // Reset in the middle of an emission must discard the request
    @(negedge clk);
    model(15);
    pending = 1'b1;
    start_i = 1'b1;
    num_i = 5'd15;
    @(posedge clk);
    #1 start_i = 1'b0;
    hop_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid_emit_valid", int'(hop_valid_o), 1);
    rst_n = 1'b0;
    pending = 1'b0;
    exp_done_next = 1'b0;
    hq.delete();
    @(posedge clk);
    #1 chk("mid_reset_outputs", int'({busy_o, hop_valid_o, hop_last_o, done_o, err_o,
                                      grp_cnt_o, hop_grp_o, hop_dim_o, hop_base_o}), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_reset_idle", int'(busy_o), 0);
    run(12, 100, 1'b0);
    for (int i = 0; i < 30; i++) run($urandom_range(31), $urandom_range(100, 30), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
